// File: rtl/rv32i_types.sv
// Shared RV32 decode types; the divide-class funct3 encodings live here.
// Pure declarations: no latency, no flow control.
package rv32i_types;

  typedef enum logic [2:0] {
    F3_DIV  = 3'b100,
    F3_DIVU = 3'b101,
    F3_REM  = 3'b110,
    F3_REMU = 3'b111
  } div_funct3_t;

  localparam logic [31:0] DIV_INT_MIN  = 32'h8000_0000;
  localparam logic [31:0] DIV_ALL_ONES = 32'hFFFF_FFFF;

  function automatic logic f3_is_signed(input logic [2:0] f3);
    return !f3[0];
  endfunction

  function automatic logic f3_is_rem(input logic [2:0] f3);
    return f3[1];
  endfunction

endpackage

// File: rtl/div_sign_fix.sv
// Restores operand signs onto the unsigned divider output and selects quotient or remainder.
// Combinational, zero latency; no flow control.
module div_sign_fix
  import rv32i_types::*;
(
  input  logic        neg_a,
  input  logic        neg_b,
  input  logic [31:0] div_quo,
  input  logic [31:0] div_rem,
  input  logic [2:0]  funct3,
  output logic [31:0] result
);

  logic [31:0] quo_fix;
  logic [31:0] rem_fix;

  always_comb begin
    quo_fix = (neg_a ^ neg_b) ? (32'd0 - div_quo) : div_quo;
    // Remainder takes the sign of the dividend only.
    rem_fix = neg_a ? (32'd0 - div_rem) : div_rem;
    result  = f3_is_rem(funct3) ? rem_fix : quo_fix;
  end

endmodule

// File: rtl/div_unit.sv
// EX-stage front end for the shared unsigned divider: sign handling, start/done handshake, RISC-V corner cases.
// 1 cycle after accept on zero-divisor/overflow, else divider time plus 3; stalls EX until resp_valid or flush.
module div_unit
  import rv32i_types::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  input  logic [2:0]  funct3,
  input  logic [31:0] rs1,
  input  logic [31:0] rs2,
  input  logic        flush,
  output logic        stall,
  output logic        resp_valid,
  output logic [31:0] result,
  output logic [31:0] div_a,
  output logic [31:0] div_b,
  output logic        div_start,
  input  logic [31:0] div_quo,
  input  logic [31:0] div_rem,
  input  logic        div_done
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LAUNCH,
    S_WAIT_LOW,
    S_WAIT_HIGH,
    S_DONE,
    S_DRAIN
  } state_t;

  state_t      state_q, state_d;
  div_funct3_t funct3_q, funct3_d;
  logic        neg_a_q, neg_a_d;
  logic        neg_b_q, neg_b_d;
  logic [31:0] mag_a_q, mag_a_d;
  logic [31:0] mag_b_q, mag_b_d;
  logic [31:0] result_q, result_d;

  logic        in_signed;
  logic        in_neg_a;
  logic        in_neg_b;
  logic        div_zero;
  logic        overflow;
  logic        accept;

  logic        fix_neg_a;
  logic        fix_neg_b;
  logic [31:0] fix_quo;
  logic [31:0] fix_rem;
  logic [2:0]  fix_f3;
  logic [31:0] fix_result;

  always_comb begin
    in_signed = f3_is_signed(funct3);
    in_neg_a  = in_signed & rs1[31];
    in_neg_b  = in_signed & rs2[31];
    div_zero  = (rs2 == 32'd0);
    overflow  = in_signed && (rs1 == DIV_INT_MIN) && (rs2 == DIV_ALL_ONES);
    accept    = (state_q == S_IDLE) && req_valid && !flush;
  end

  // In IDLE the sign fixer resolves the fast paths from raw operands with signs
  // forced off, so the architectural constants pass through unchanged.
  always_comb begin
    if (state_q == S_IDLE) begin
      fix_neg_a = 1'b0;
      fix_neg_b = 1'b0;
      fix_quo   = div_zero ? DIV_ALL_ONES : DIV_INT_MIN;
      fix_rem   = div_zero ? rs1 : 32'd0;
      fix_f3    = funct3;
    end else begin
      fix_neg_a = neg_a_q;
      fix_neg_b = neg_b_q;
      fix_quo   = div_quo;
      fix_rem   = div_rem;
      fix_f3    = funct3_q;
    end
  end

  div_sign_fix u_sign_fix (
    .neg_a   (fix_neg_a),
    .neg_b   (fix_neg_b),
    .div_quo (fix_quo),
    .div_rem (fix_rem),
    .funct3  (fix_f3),
    .result  (fix_result)
  );

  always_comb begin
    state_d  = state_q;
    funct3_d = funct3_q;
    neg_a_d  = neg_a_q;
    neg_b_d  = neg_b_q;
    mag_a_d  = mag_a_q;
    mag_b_d  = mag_b_q;
    result_d = result_q;

    unique case (state_q)
      S_IDLE: begin
        if (accept) begin
          funct3_d = div_funct3_t'(funct3);
          neg_a_d  = in_neg_a;
          neg_b_d  = in_neg_b;
          mag_a_d  = in_neg_a ? (32'd0 - rs1) : rs1;
          mag_b_d  = in_neg_b ? (32'd0 - rs2) : rs2;
          if (div_zero || overflow) begin
            result_d = fix_result;
            state_d  = S_DONE;
          end else begin
            state_d  = S_LAUNCH;
          end
        end
      end
      // The divider has no reset, so a start is only issued once it reports idle.
      S_LAUNCH: begin
        if (flush)         state_d = S_IDLE;
        else if (div_done) state_d = S_WAIT_LOW;
      end
      S_WAIT_LOW: begin
        if (flush)          state_d = S_DRAIN;
        else if (!div_done) state_d = S_WAIT_HIGH;
      end
      S_WAIT_HIGH: begin
        if (flush) begin
          state_d = S_DRAIN;
        end else if (div_done) begin
          result_d = fix_result;
          state_d  = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      S_DRAIN: begin
        if (div_done) state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      funct3_q <= F3_DIV;
      neg_a_q  <= 1'b0;
      neg_b_q  <= 1'b0;
      mag_a_q  <= 32'd0;
      mag_b_q  <= 32'd0;
      result_q <= 32'd0;
    end else begin
      state_q  <= state_d;
      funct3_q <= funct3_d;
      neg_a_q  <= neg_a_d;
      neg_b_q  <= neg_b_d;
      mag_a_q  <= mag_a_d;
      mag_b_q  <= mag_b_d;
      result_q <= result_d;
    end
  end

  always_comb begin
    stall      = accept || (state_q == S_LAUNCH) || (state_q == S_WAIT_LOW) ||
                 (state_q == S_WAIT_HIGH);
    resp_valid = (state_q == S_DONE);
    result     = result_q;
    div_start  = (state_q == S_LAUNCH) && div_done && !flush;
    // The divider samples b live, so magnitudes stay parked on the bus.
    div_a      = mag_a_q;
    div_b      = mag_b_q;
  end

endmodule
